// File: rtl/apu_pulse_bank_pkg.sv
// apu_pulse_bank_pkg: shared APU types and tables for the pulse channel bank.
// Holds the per-channel register image, the duty waveforms and the NES
// length-counter lookup.
package apu_pulse_bank_pkg;

    // Decoded image of one pulse channel's four write-only registers
    typedef struct packed {
        logic [1:0]  duty;
        logic        halt;          // length halt, doubles as envelope loop
        logic        const_vol;
        logic [3:0]  vol;           // constant volume or envelope period
        logic        sweep_en;
        logic [2:0]  sweep_period;
        logic        negate;
        logic [2:0]  shift;
        logic [10:0] period;        // timer reload value
    } pulse_regs_t;

    // Duty waveforms; bit 7 is sequencer step 0, bit 0 is step 7
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b10011111,   // duty 3
        8'b01111000,   // duty 2
        8'b01100000,   // duty 1
        8'b01000000    // duty 0
    };

    // Length counter load values indexed by reg3[7:3]
    function automatic logic [7:0] length_lookup(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
            5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
            5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
            5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
            5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
            5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;
            default: v = 8'd30;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/apu_pulse_bank_if.sv
// apu_pulse_bank_if: CPU register write bus into the pulse bank.
interface apu_pulse_bank_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_data;
    logic              reg_en;
    logic              reg_we;

    modport master (output reg_addr, reg_data, reg_en, reg_we);
    modport slave  (input  reg_addr, reg_data, reg_en, reg_we);
endinterface

// File: rtl/apu_pulse_bank_pulse_unit.sv
// pulse_unit: one NES-style pulse channel (timer, duty sequencer, envelope,
// length counter, optional sweep). Sweep logic is built only when
// APU_SWEEP_EN is defined; otherwise reg1 is stored but has no effect.
module pulse_unit
    import apu_pulse_bank_pkg::*;
#(
    parameter int CH_IDX = 0
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       apu_clk_en,
    input  logic       quarter_clk_en,
    input  logic       half_clk_en,
    input  logic [3:0] wr_sel,        // one-hot reg0..reg3 write strobe
    input  logic [7:0] wr_data,
    input  logic       status_wr,
    input  logic       status_bit,
    output logic [3:0] sample,
    output logic       len_nz
);
    pulse_regs_t regs;
    logic [10:0] timer;
    logic [2:0]  step;
    logic [7:0]  length;
    logic        enable, enable_nxt;
    logic        env_start;
    logic [3:0]  env_div, decay;
    logic        muted, sweep_mute, duty_bit;

    assign enable_nxt = status_wr ? status_bit : enable;

`ifdef APU_SWEEP_EN
    logic [10:0] change;
    logic [11:0] diff, target;
    logic [2:0]  sweep_div;
    logic        sweep_reload, sweep_fire;

    assign change = regs.period >> regs.shift;
    // Channel 0 negates in ones-complement (one extra subtracted)
    assign diff   = {1'b0, regs.period} - {1'b0, change} - ((CH_IDX == 0) ? 12'd1 : 12'd0);

    // Sweep target; a negated result below zero (shift 0 on channel 0) clamps to 0
    always_comb begin
        if (regs.negate) target = diff[11] ? 12'd0 : diff;
        else             target = {1'b0, regs.period} + {1'b0, change};
    end

    assign sweep_mute = target[11];
    assign sweep_fire = half_clk_en && (sweep_div == 3'd0) && regs.sweep_en &&
                        (regs.shift != 3'd0) && !muted;

    // Sweep divider: reload when expired or after a reg1 write
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sweep_div    <= 3'd0;
            sweep_reload <= 1'b0;
        end else begin
            if (half_clk_en) begin
                if (sweep_div == 3'd0 || sweep_reload) begin
                    sweep_div    <= regs.sweep_period;
                    sweep_reload <= 1'b0;
                end else begin
                    sweep_div <= sweep_div - 3'd1;
                end
            end
            if (wr_sel[1]) sweep_reload <= 1'b1;
        end
    end
`else
    logic sweep_unused;
    assign sweep_mute   = 1'b0;
    assign sweep_unused = ^{regs.sweep_en, regs.sweep_period, regs.negate, regs.shift, CH_IDX[0]};
`endif

    assign muted = (length == 8'd0) || (regs.period < 11'd8) || sweep_mute;

    // Register image and channel enable; CPU period writes win over a sweep update
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            regs   <= '0;
            enable <= 1'b0;
        end else begin
            enable <= enable_nxt;
            if (wr_sel[0]) {regs.duty, regs.halt, regs.const_vol, regs.vol} <= wr_data;
            if (wr_sel[1]) {regs.sweep_en, regs.sweep_period, regs.negate, regs.shift} <= wr_data;
            if (wr_sel[2])      regs.period <= {regs.period[10:8], wr_data};
            else if (wr_sel[3]) regs.period <= {wr_data[2:0], regs.period[7:0]};
`ifdef APU_SWEEP_EN
            else if (sweep_fire) regs.period <= target[10:0];
`endif
        end
    end

    // Period timer and 8-step duty sequencer; reg3 write restarts the sequence
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            timer <= 11'd0;
            step  <= 3'd0;
        end else begin
            if (apu_clk_en) begin
                if (timer == 11'd0) begin
                    timer <= regs.period;
                    step  <= step + 3'd1;
                end else begin
                    timer <= timer - 11'd1;
                end
            end
            if (wr_sel[3]) step <= 3'd0;
        end
    end

    // Envelope generator on the quarter-frame strobe
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            env_start <= 1'b0;
            env_div   <= 4'd0;
            decay     <= 4'd0;
        end else begin
            if (quarter_clk_en) begin
                if (env_start) begin
                    env_start <= 1'b0;
                    decay     <= 4'd15;
                    env_div   <= regs.vol;
                end else if (env_div == 4'd0) begin
                    env_div <= regs.vol;
                    if (decay != 4'd0) decay <= decay - 4'd1;
                    else if (regs.halt) decay <= 4'd15;
                end else begin
                    env_div <= env_div - 4'd1;
                end
            end
            if (wr_sel[3]) env_start <= 1'b1;
        end
    end

    // Length counter: disable clears, reg3 load beats the half-frame decrement
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                                    length <= 8'd0;
        else if (!enable_nxt)                          length <= 8'd0;
        else if (wr_sel[3] && enable)                  length <= length_lookup(wr_data[7:3]);
        else if (half_clk_en && length != 8'd0 && !regs.halt) length <= length - 8'd1;
    end

    assign duty_bit = DUTY_TABLE[regs.duty][3'd7 - step];
    assign sample   = (muted || !duty_bit) ? 4'd0 : (regs.const_vol ? regs.vol : decay);
    assign len_nz   = (length != 8'd0);

endmodule

// File: rtl/apu_pulse_bank.sv
// apu_pulse_bank: NUM_PULSE pulse channels behind one register bus, with a
// registered mixer. Channel i owns addresses 4i..4i+3, status sits at
// 4*NUM_PULSE. Define APU_SWEEP_EN to build the frequency sweep units.
module apu_pulse_bank
    import apu_pulse_bank_pkg::*;
#(
    parameter int NUM_PULSE = 2,
    parameter int ADDR_W    = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  logic                                 cpu_clk_en,
    input  logic                                 apu_clk_en,
    input  logic                                 quarter_clk_en,
    input  logic                                 half_clk_en,
    apu_pulse_bank_if.slave                      bus,
    output logic [NUM_PULSE-1:0][3:0]            ch_out,
    output logic [4+$clog2(NUM_PULSE+1)-1:0]     mix_out,
    output logic [NUM_PULSE-1:0]                 length_non_zero
);
    localparam int MIX_W = 4 + $clog2(NUM_PULSE + 1);

    logic                       reg_wr, status_wr;
    logic [NUM_PULSE-1:0][3:0]  wr_sel;
    logic [MIX_W-1:0]           mix_sum;

    assign reg_wr    = cpu_clk_en && bus.reg_en && bus.reg_we;
    assign status_wr = reg_wr && (bus.reg_addr == ADDR_W'(4 * NUM_PULSE));

    for (genvar g = 0; g < NUM_PULSE; g++) begin : g_ch
        assign wr_sel[g] = (reg_wr && bus.reg_addr[ADDR_W-1:2] == (ADDR_W-2)'(g)) ?
                           (4'b0001 << bus.reg_addr[1:0]) : 4'b0000;

        pulse_unit #(.CH_IDX(g)) u_pulse (
            .clk            (clk),
            .rst_l          (rst_l),
            .apu_clk_en     (apu_clk_en),
            .quarter_clk_en (quarter_clk_en),
            .half_clk_en    (half_clk_en),
            .wr_sel         (wr_sel[g]),
            .wr_data        (bus.reg_data),
            .status_wr      (status_wr),
            .status_bit     (bus.reg_data[g]),
            .sample         (ch_out[g]),
            .len_nz         (length_non_zero[g])
        );
    end

    // Sum of channel samples; width already covers NUM_PULSE*15
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_PULSE; i++) mix_sum = mix_sum + MIX_W'(ch_out[i]);
    end

    // Mixer output register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) mix_out <= '0;
        else        mix_out <= mix_sum;
    end

endmodule

// File: tb/tb_apu_pulse_bank.sv
// tb_apu_pulse_bank: directed scenarios plus randomized traffic, every cycle
// checked against a behavioural channel model.
module tb_apu_pulse_bank;
    localparam int NP = 2;
    localparam int AW = 5;
    localparam int MW = 4 + $clog2(NP + 1);

    logic clk = 1'b0, rst_l = 1'b1;
    logic cpu_en = 1'b0, apu_en = 1'b0, q_en = 1'b0, h_en = 1'b0;
    logic [NP-1:0][3:0] ch_out;
    logic [MW-1:0]      mix_out;
    logic [NP-1:0]      lnz;

    apu_pulse_bank_if #(.ADDR_W(AW)) bus ();

    apu_pulse_bank #(.NUM_PULSE(NP), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .cpu_clk_en     (cpu_en),
        .apu_clk_en     (apu_en),
        .quarter_clk_en (q_en),
        .half_clk_en    (h_en),
        .bus            (bus),
        .ch_out         (ch_out),
        .mix_out        (mix_out),
        .length_non_zero(lnz)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int len_tab[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                        12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
    string duty_pat[4] = '{"01000000", "01100000", "01111000", "10011111"};

    // model state, one entry per channel
    int m_reg0[NP], m_reg1[NP], m_per[NP], m_tc[NP], m_step[NP], m_len[NP];
    int m_en[NP], m_est[NP], m_ediv[NP], m_dec[NP], m_sdiv[NP], m_srl[NP];
    int m_mix;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int duty_hi(int d, int s);
        string p;
        p = duty_pat[d];
        return (p[s] == "1") ? 1 : 0;
    endfunction

    function automatic int target(int i);
        int ch, t;
        ch = m_per[i] >> (m_reg1[i] & 7);
        if ((m_reg1[i] >> 3) & 1) begin
            t = m_per[i] - ch - ((i == 0) ? 1 : 0);
            return (t < 0) ? 0 : t;
        end
        return m_per[i] + ch;
    endfunction

    function automatic int muted(int i);
        int mu;
        mu = (m_len[i] == 0 || m_per[i] < 8) ? 1 : 0;
`ifdef APU_SWEEP_EN
        if (target(i) > 'h7FF) mu = 1;
`endif
        return mu;
    endfunction

    function automatic int exp_out(int i);
        if (muted(i) != 0 || duty_hi(m_reg0[i] >> 6, m_step[i]) == 0) return 0;
        return ((m_reg0[i] >> 4) & 1) ? (m_reg0[i] & 15) : m_dec[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_reg0[i] = 0; m_reg1[i] = 0; m_per[i] = 0; m_tc[i] = 0; m_step[i] = 0; m_len[i] = 0;
            m_en[i] = 0; m_est[i] = 0; m_ediv[i] = 0; m_dec[i] = 0; m_sdiv[i] = 0; m_srl[i] = 0;
        end
        m_mix = 0;
    endtask

    // One clock of channel behaviour, evaluated from the pre-edge state and inputs
    task automatic model_step();
        int sum, d, r, per, r1, vol, halt, mu, tg, nen;
        bit wr, stat, chw;
        sum = 0;
        for (int i = 0; i < NP; i++) sum += exp_out(i);
        wr   = cpu_en && bus.reg_en && bus.reg_we;
        stat = wr && (int'(bus.reg_addr) == 4 * NP);
        d    = int'(bus.reg_data);
        r    = int'(bus.reg_addr) % 4;
        for (int i = 0; i < NP; i++) begin
            per  = m_per[i];
            r1   = m_reg1[i];
            vol  = m_reg0[i] & 15;
            halt = (m_reg0[i] >> 5) & 1;
            mu   = muted(i);
            tg   = target(i);
            chw  = wr && (int'(bus.reg_addr) / 4 == i);
            nen  = stat ? ((d >> i) & 1) : m_en[i];
            if (apu_en) begin
                if (m_tc[i] == 0) begin m_tc[i] = per; m_step[i] = (m_step[i] + 1) % 8; end
                else m_tc[i]--;
            end
            if (q_en) begin
                if (m_est[i] != 0) begin m_est[i] = 0; m_dec[i] = 15; m_ediv[i] = vol; end
                else if (m_ediv[i] == 0) begin
                    m_ediv[i] = vol;
                    if (m_dec[i] > 0) m_dec[i]--;
                    else if (halt != 0) m_dec[i] = 15;
                end else m_ediv[i]--;
            end
            if (h_en && m_len[i] != 0 && halt == 0) m_len[i]--;
`ifdef APU_SWEEP_EN
            if (h_en) begin
                if (m_sdiv[i] == 0 && (r1 >> 7) != 0 && (r1 & 7) != 0 && mu == 0) m_per[i] = tg;
                if (m_sdiv[i] == 0 || m_srl[i] != 0) begin m_sdiv[i] = (r1 >> 4) & 7; m_srl[i] = 0; end
                else m_sdiv[i]--;
            end
`endif
            if (chw) begin
                case (r)
                    0: m_reg0[i] = d;
                    1: begin m_reg1[i] = d; m_srl[i] = 1; end
                    2: m_per[i] = (per & 'h700) | d;
                    default: begin
                        m_per[i]  = (per & 'hFF) | ((d & 7) << 8);
                        m_step[i] = 0;
                        m_est[i]  = 1;
                        if (m_en[i] != 0) m_len[i] = len_tab[d >> 3];
                    end
                endcase
            end
            if (nen == 0) m_len[i] = 0;
            m_en[i] = nen;
        end
        m_mix = sum;
    endtask

    // Advance one clock and compare every output against the model
    task automatic tick();
        @(posedge clk);
        if (!rst_l) model_reset();
        else        model_step();
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            chk("ch_out", 32'(ch_out[i]), 32'(exp_out(i)));
            chk("len_nz", 32'(lnz[i]), (m_len[i] != 0) ? 32'd1 : 32'd0);
        end
        chk("mix_out", 32'(mix_out), 32'(m_mix));
    endtask

    task automatic wr_reg(input int a, input int d);
        bus.reg_addr = AW'(a);
        bus.reg_data = 8'(d);
        bus.reg_en   = 1'b1;
        bus.reg_we   = 1'b1;
        cpu_en       = 1'b1;
        tick();
        bus.reg_en = 1'b0;
        bus.reg_we = 1'b0;
        cpu_en     = 1'b0;
    endtask

    initial begin
        int step, rise_cnt[NP], rise_at[NP][2], prev[NP];
        bus.reg_addr = '0; bus.reg_data = '0; bus.reg_en = 1'b0; bus.reg_we = 1'b0;
        model_reset();
        #1 rst_l = 1'b0;

        // everything active while reset is held: outputs must stay 0
        cpu_en = 1; apu_en = 1; q_en = 1; h_en = 1;
        bus.reg_en = 1; bus.reg_we = 1; bus.reg_addr = AW'(4 * NP); bus.reg_data = 8'hFF;
        repeat (3) tick();
        chk("rst_ch_out", 32'(ch_out), 32'd0);
        chk("rst_mix", 32'(mix_out), 32'd0);
        chk("rst_lnz", 32'(lnz), 32'd0);
        cpu_en = 0; apu_en = 0; q_en = 0; h_en = 0; bus.reg_en = 0; bus.reg_we = 0;
        rst_l = 1'b1;

        // duty 2, constant volume 15, period 8 -> 9 apu clocks per step
        wr_reg(4 * NP, 'h01);
        wr_reg(0, 'hBF);
        wr_reg(2, 'h08);
        wr_reg(3, 'h08);
        chk("duty_step0", 32'(ch_out[0]), 32'd0);
        apu_en = 1;
        for (int c = 1; c <= 72; c++) begin
            tick();
            step = (1 + (c - 1) / 9) % 8;
            chk("duty_seq", 32'(ch_out[0]), (step >= 1 && step <= 4) ? 32'd15 : 32'd0);
        end
        apu_en = 0;

        // disable mid-note, then a reg3 write must not reload the length
        wr_reg(4 * NP, 'h00);
        chk("dis_lnz", 32'(lnz[0]), 32'd0);
        chk("dis_ch_out", 32'(ch_out[0]), 32'd0);
        wr_reg(3, 'h08);
        chk("dis_noload", 32'(lnz[0]), 32'd0);

        // length 254 with halt clear expires on exactly the 254th half-frame
        wr_reg(4 * NP, 'h01);
        wr_reg(0, 'h9F);
        wr_reg(3, 'h08);
        chk("len_load", 32'(lnz[0]), 32'd1);
        for (int n = 1; n <= 254; n++) begin
            h_en = 1; tick(); h_en = 0;
            chk("len_count", 32'(lnz[0]), (n < 254) ? 32'd1 : 32'd0);
            tick();
        end

        // looping envelope with vol 0: 15,14..0,15
        wr_reg(0, 'hE0);
        wr_reg(2, 'h08);
        wr_reg(3, 'h08);
        for (int j = 0; j <= 16; j++) begin
            q_en = 1; tick(); q_en = 0;
            chk("env_decay", 32'(ch_out[0]), (j == 0 || j == 16) ? 32'd15 : 32'(15 - j));
        end
        tick();

        // asynchronous reset mid-note, checked before any clock edge
        #3 rst_l = 1'b0;
        model_reset();
        #1;
        chk("arst_ch_out", 32'(ch_out), 32'd0);
        chk("arst_mix", 32'(mix_out), 32'd0);
        chk("arst_lnz", 32'(lnz), 32'd0);
        tick();
        rst_l = 1'b1;

`ifdef APU_SWEEP_EN
        // period 0x100, shift 1, negate: ch0 -> 0x7F, ch1 -> 0x80
        wr_reg(4 * NP, 'h03);
        for (int c = 0; c < NP; c++) begin
            wr_reg(4 * c + 0, 'h3F);
            wr_reg(4 * c + 2, 'h00);
            wr_reg(4 * c + 3, 'h09);
            wr_reg(4 * c + 1, 'h89);
        end
        h_en = 1; tick(); h_en = 0;
        for (int c = 0; c < NP; c++) begin rise_cnt[c] = 0; prev[c] = 0; end
        apu_en = 1;
        for (int k = 1; k <= 3000 && (rise_cnt[0] < 2 || rise_cnt[1] < 2); k++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (ch_out[c] != 0 && prev[c] == 0 && rise_cnt[c] < 2) begin
                    rise_at[c][rise_cnt[c]] = k;
                    rise_cnt[c]++;
                end
                prev[c] = int'(ch_out[c]);
            end
        end
        apu_en = 0;
        chk("sweep_ch0", (rise_cnt[0] == 2) ? 32'(rise_at[0][1] - rise_at[0][0]) : 32'hFFFF_FFFF, 32'd1024);
        chk("sweep_ch1", (rise_cnt[1] == 2) ? 32'(rise_at[1][1] - rise_at[1][0]) : 32'hFFFF_FFFF, 32'd1032);
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cpu_en = ($urandom % 4) != 0;
            apu_en = $urandom % 2;
            q_en   = ($urandom % 24) == 0;
            h_en   = ($urandom % 24) == 0;
            bus.reg_en = ($urandom % 6) == 0;
            bus.reg_we = ($urandom % 5) != 0;
            if ($urandom % 10 == 0) bus.reg_addr = AW'($urandom);
            else                    bus.reg_addr = AW'($urandom_range(0, 4 * NP));
            bus.reg_data = 8'($urandom);
            if (int'(bus.reg_addr) == 4 * NP && ($urandom % 6) != 0) bus.reg_data = 8'hFF;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/apu_pulse_bank.md
APU_PULSE_BANK -- requirements
Module: apu_pulse_bank

Interface
REQ-001 SHALL have parameter NUM_PULSE, default 2, meaning number of pulse channels (range 1..8).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width (must satisfy 2^ADDR_W > 4*NUM_PULSE).
REQ-003 SHALL have port clk  input  1  system clock, the only clock.
REQ-004 SHALL have port rst_l  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_clk_en / apu_clk_en  input  1 each  CPU-rate and APU-rate (half CPU) clock enables.
REQ-006 SHALL have port quarter_clk_en / half_clk_en  input  1 each  frame-counter envelope and length/sweep strobes.
REQ-007 SHALL have port reg_addr  input  ADDR_W  register address.
REQ-008 SHALL have port reg_data  input  8  write data.
REQ-009 SHALL have port reg_en, reg_we  input  1 each  register access strobe; a write occurs only when both are high on a cpu_clk_en cycle.
REQ-010 SHALL have port ch_out  output  NUM_PULSE x 4  per-channel volume sample.
REQ-011 SHALL have port mix_out  output  4+$clog2(NUM_PULSE+1)  registered sum of all ch_out.
REQ-012 SHALL have port length_non_zero  output  NUM_PULSE  per-channel length counter != 0.

Function
REQ-013 SHALL map channel i registers at addresses 4i+0..4i+3 and the status register at 4*NUM_PULSE; other addresses are ignored.
REQ-014 SHALL decode reg0 as duty[7:6], length_halt/env_loop[5], const_vol[4], vol[3:0]; reg1 as sweep_en[7], sweep_period[6:4], negate[3], shift[2:0]; reg2 as timer[7:0]; reg3 as length_index[7:3], timer[10:8].
REQ-015 SHALL, on a reg3 write: load length from the 32-entry NES length table if status bit i is set; reset sequencer step to 0; set envelope start flag.
REQ-016 SHALL, on status write, latch bit i as channel i enable; a cleared enable forces that length counter to 0 on the next cycle and blocks loads.
REQ-017 SHALL, on apu_clk_en: if timer==0, reload the 11-bit period and advance the step by 1 mod 8; else decrement the timer.
REQ-018 SHALL use duty sequences (steps 0..7): 0=01000000, 1=01100000, 2=01111000, 3=10011111.
REQ-019 SHALL, on quarter_clk_en, run the envelope: if start flag set, clear it, decay=15, divider=vol; else if divider==0, divider=vol and decay-- if decay>0, else decay=15 when env_loop; else divider--.
REQ-020 SHALL, on half_clk_en, decrement length when length!=0 and length_halt==0; a simultaneous reg3 load wins over the decrement.
REQ-021 SHALL output ch_out[i]=0 when muted (length==0, period<8, or sweep target>0x7FF) or duty bit is 0; otherwise const_vol ? vol : decay.
REQ-022 SHALL register mix_out one cycle after ch_out changes; no saturation (width covers NUM_PULSE*15).

Reset
REQ-023 SHALL clear all registers, timers, steps, length counters, envelopes, sweep state and enables on rst_l low, asynchronously; ch_out, mix_out, length_non_zero = 0.
REQ-024 SHALL keep all outputs 0 until rst_l deasserts, even if enables or writes are presented during reset.

Configuration
REQ-025 SHALL, with APU_SWEEP_EN defined, implement per-channel sweep: target = period +/- (period>>shift); channel 0 negate subtracts an extra 1 (ones-complement), others two's-complement; on half_clk_en, if divider==0 and sweep_en and shift!=0 and not muted, period<=target; divider reloads to sweep_period when 0 or after a reg1 write, else decrements.
REQ-026 SHALL, without APU_SWEEP_EN, store reg1 but ignore it; mute uses only length==0 and period<8.

Structure
REQ-027 SHALL place the length table, duty table and pulse register struct typedefs in the shared APU package.
REQ-028 SHALL instantiate NUM_PULSE copies of one sub-module, pulse_unit, via generate; address decode and mixer live in apu_pulse_bank.

Verification
REQ-029 SHALL cover: ch0 reg0=0xBF, reg2=0x08, reg3=0x08, status=0x01 -> ch_out[0] toggles 15/0 with duty 2 pattern, step period 9 apu_clk_en.
REQ-030 SHALL cover: length_index=1 (254), halt=0, 254 half_clk_en pulses -> length_non_zero[0] falls exactly on the 254th.
REQ-031 SHALL cover: const_vol=0, vol=0, loop=1 -> decay steps 15,14..0,15 on successive quarter_clk_en.
REQ-032 SHALL cover: status write 0x00 mid-note -> length_non_zero and ch_out go 0 next cycle; later reg3 write does not reload.
REQ-033 SHALL cover (APU_SWEEP_EN): period 0x100, shift=1, negate=1 -> ch0 target 0x7F, ch1 target 0x80.
REQ-034 SHALL cover: rst_l low mid-note -> all outputs 0 immediately, with no clock edge required.
